// File: rtl/div_clk_mc.sv
// Multi-channel programmable clock divider / tick generator. Each channel emits a wrap strobe and a pulse-or-square
// divided clock, with divisor and mode reloaded only at wrap, idle or sync. Define DIV_CLK_NEGEDGE_EN to move all state to the falling edge.
module div_clk_mc #(
  parameter int CNT_W = 8,
  parameter int N_CH  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_sync,
  input  logic [N_CH*CNT_W-1:0]   i_div,
  input  logic [N_CH-1:0]         i_mode,
  output logic [N_CH-1:0]         o_clk,
  output logic [N_CH-1:0]         o_tick,
  output logic [N_CH-1:0]         o_busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, d_act, cnt_n, d_n, div_in, half;
    logic             m_act, m_n, upd, tick, sq, clk_q, tick_q;

    assign div_in = i_div[c*CNT_W +: CNT_W];

    // Sync wins over everything; otherwise the enable gates both counting and reloads.
    always_comb begin
      cnt_n = cnt;
      d_n   = d_act;
      m_n   = m_act;
      upd   = 1'b0;
      if (i_sync) begin
        cnt_n = '0;
        d_n   = div_in;
        m_n   = i_mode[c];
        upd   = 1'b1;
      end else if (i_en) begin
        upd = 1'b1;
        if (d_act == '0 || cnt == d_act - ONE) begin
          cnt_n = '0;
          d_n   = div_in;
          m_n   = i_mode[c];
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    end

    // ceil(D/2) without the carry that (D+1)>>1 would lose at D = 2^CNT_W-1.
    assign half = (d_n >> 1) + {{(CNT_W-1){1'b0}}, d_n[0]};
    assign tick = (d_n != '0) && (cnt_n == d_n - ONE);
    assign sq   = cnt_n < half;

`ifdef DIV_CLK_NEGEDGE_EN
    always_ff @(negedge i_clk or negedge i_rst_n) begin
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
`endif
      if (!i_rst_n) begin
        cnt    <= '0;
        d_act  <= '0;
        m_act  <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (upd) begin
        cnt    <= cnt_n;
        d_act  <= d_n;
        m_act  <= m_n;
        tick_q <= tick;
        clk_q  <= m_n ? sq : tick;
      end
    end

    assign o_clk[c]  = clk_q;
    assign o_tick[c] = tick_q;
    assign o_busy[c] = (d_act != '0);
  end

endmodule

// File: tb/tb_div_clk_mc.sv
// Self-checking bench for div_clk_mc: hand-computed vector table plus a cycle-level scoreboard model.
module tb_div_clk_mc;

  logic        clk, rst_n, en, sync;
  logic [15:0] div;
  logic [1:0]  mode;
  logic [1:0]  o_clk, o_tick, o_busy;

  div_clk_mc #(.CNT_W(8), .N_CH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sync(sync),
    .i_div(div), .i_mode(mode),
    .o_clk(o_clk), .o_tick(o_tick), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, sync;
    logic [15:0] div;
    logic [1:0]  mode;
    logic [1:0]  clk, tick, busy;
  } vec_t;

  typedef struct {
    logic [1:0] clk, tick, busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference model state, one entry per channel.
  int         mcnt[2];
  int         md[2];
  bit         mm[2];
  logic [1:0] eclk, etick;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mcnt[c] = 0; md[c] = 0; mm[c] = 1'b0;
    end
    eclk  = 2'b00;
    etick = 2'b00;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    exp_t e;
    int   dv;
    for (int c = 0; c < 2; c++) begin
      dv = int'(div[c*8 +: 8]);
      if (sync || (en && (md[c] == 0 || mcnt[c] == md[c] - 1))) begin
        mcnt[c] = 0;
        md[c]   = dv;
        mm[c]   = mode[c];
      end else if (en) begin
        mcnt[c] = mcnt[c] + 1;
      end
      if (sync || en) begin
        etick[c] = (md[c] != 0) && (mcnt[c] == md[c] - 1);
        eclk[c]  = mm[c] ? (mcnt[c] < (md[c] + 1) / 2) : etick[c];
      end
    end
    e.clk  = eclk;
    e.tick = etick;
    e.busy = {md[1] != 0, md[0] != 0};
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk("sb_clk",  {14'd0, o_clk},  {14'd0, e.clk});
      chk("sb_tick", {14'd0, o_tick}, {14'd0, e.tick});
      chk("sb_busy", {14'd0, o_busy}, {14'd0, e.busy});
    end
  endtask

  vec_t tbl[14];
  int   first_tick;

  initial begin
    // ch0: D=3 pulse, ch1: D=5 square; outputs listed as {ch1,ch0}.
    tbl[0]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[1]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[2]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b11, 2'b01, 2'b11};
    tbl[3]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b00, 2'b00, 2'b11};
    tbl[4]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b00, 2'b10, 2'b11};
    tbl[5]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b11, 2'b01, 2'b11};
    tbl[6]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[7]  = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[8]  = '{1'b0, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[9]  = '{1'b0, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[10] = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b01, 2'b01, 2'b11};
    tbl[11] = '{1'b1, 1'b1, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[12] = '{1'b0, 1'b1, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};
    tbl[13] = '{1'b1, 1'b0, 16'h0503, 2'b10, 2'b10, 2'b00, 2'b11};

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; div = 16'h0000; mode = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_clk",  {14'd0, o_clk},  16'h0000);
    chk("reset_tick", {14'd0, o_tick}, 16'h0000);
    chk("reset_busy", {14'd0, o_busy}, 16'h0000);
    rst_n = 1'b1;

    // Table: hand-derived waveforms incl. enable freeze and sync with enable low.
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; sync = tbl[i].sync; div = tbl[i].div; mode = tbl[i].mode;
      step();
      chk($sformatf("tbl%0d_clk", i),  {14'd0, o_clk},  {14'd0, tbl[i].clk});
      chk($sformatf("tbl%0d_tick", i), {14'd0, o_tick}, {14'd0, tbl[i].tick});
      chk($sformatf("tbl%0d_busy", i), {14'd0, o_busy}, {14'd0, tbl[i].busy});
    end
    sync = 1'b0;

    // D=8 pulse, switch to 3 at cnt=2: old period finishes, then period 3.
    en = 1'b1; sync = 1'b1; div = 16'h0008; mode = 2'b00;
    step();
    sync = 1'b0;
    step(); step();
    div = 16'h0003;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("divchg_tick%0d", k), {15'd0, o_tick[0]},
          {15'd0, (k == 4 || k == 7 || k == 10)});
      chk($sformatf("divchg_pulse%0d", k), {15'd0, o_clk[0]}, {15'd0, o_tick[0]});
    end

    // Enable low for 4 cycles mid-period, then sync while disabled.
    div = 16'h0705; mode = 2'b11; sync = 1'b1;
    step();
    sync = 1'b0;
    step(); step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    repeat (10) step();
    en = 1'b0; sync = 1'b1;
    step();
    chk("sync_align_clk", {14'd0, o_clk}, 16'h0003);
    sync = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (12) step();

    // Divisor 0 returns to idle after the wrap; then D=1 is constantly high.
    div = 16'h0000;
    repeat (10) step();
    chk("idle_busy", {14'd0, o_busy}, 16'h0000);
    chk("idle_clk",  {14'd0, o_clk},  16'h0000);
    div = 16'h0101; mode = 2'b01;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("d1_clk%0d", k),  {14'd0, o_clk},  16'h0003);
      chk($sformatf("d1_tick%0d", k), {14'd0, o_tick}, 16'h0003);
    end

    // D=255: async reset mid-period, then fresh load.
    div = 16'h00FF; mode = 2'b01; sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (40) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk",  {14'd0, o_clk},  16'h0000);
    chk("async_rst_tick", {14'd0, o_tick}, 16'h0000);
    chk("async_rst_busy", {14'd0, o_busy}, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b00;
    first_tick = -1;
    for (int k = 1; k <= 260; k++) begin
      step();
      if (first_tick < 0 && o_tick[0]) first_tick = k;
    end
    chk("d255_first_tick", 16'(first_tick), 16'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
